// File: rtl/crc_bit_serializer_if.sv
// Byte stream feeding the CRC bit serializer: valid/ready handshake with
// start-of-frame and end-of-frame markers travelling alongside each word.
interface crc_bit_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              sop_i;
    logic              eop_i;
    logic              ready_o;

    modport master (output data_i, valid_i, sop_i, eop_i, input ready_o);
    modport slave  (input data_i, valid_i, sop_i, eop_i, output ready_o);
endinterface

// File: rtl/crc_bit_serializer.sv
// Feeds a bit-serial CRC stage: takes framed words on a valid/ready stream,
// shifts them out one bit per clock with no gaps inside a frame, pulses the
// CRC clear at each frame start and flags when the CRC result is complete.
// A one-word hold buffer sits in front of the shifter so the next word can
// arrive while the current one is still being shifted.
module crc_bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CRC_LAT   = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    crc_bit_serializer_if.slave        in_if,
    output logic                       bit_o,
    output logic                       bit_valid_o,
    output logic                       crc_rst_o,
    output logic                       crc_valid_o,
    output logic                       err_underrun_o,
    output logic                       err_sop_o
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WAIT_W = (CRC_LAT > 1) ? $clog2(CRC_LAT) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CRC_LAT > 1) ? CRC_LAT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        WAIT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_eop;
    logic                hold_full;
    logic [DATA_W-1:0]   shift_reg;
    logic                shift_eop;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                frame_open;

    logic                accept;
    logic                start_word;
    logic                last_bit;
    logic                reload_hold;
    logic                bypass;
    logic                unload;
    logic                store;
    logic                hold_full_n;
    logic                wait_next;
    logic                ready_n;
    logic [DATA_W-1:0]   load_data;
    logic                load_eop;

    // First bit presented when a fresh word enters the shifter.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    // Shifter contents after the presented bit has been removed.
    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Handshake decode and next-cycle occupancy used for the registered ready.
    // frame_open means a frame has started but its eop word is not yet in;
    // a sop word arriving then is ordinary data, otherwise it opens the next
    // frame (possibly parked in the hold buffer while the current one drains).
    // A word arriving exactly on the final bit with an empty hold goes
    // straight into the shifter so the frame stays gapless.
    always_comb begin
        accept      = in_if.valid_i & in_if.ready_o;
        start_word  = accept & ~frame_open & in_if.sop_i;
        last_bit    = (state == SHIFT) && (bit_cnt == LAST_BIT);
        reload_hold = last_bit & ~shift_eop & hold_full;
        bypass      = last_bit & ~shift_eop & ~hold_full & accept & frame_open;
        unload      = (state == CLR) | reload_hold;
        store       = accept & (frame_open | in_if.sop_i) & ~bypass;
        hold_full_n = (hold_full & ~unload) | store;
        wait_next   = (last_bit & shift_eop & (CRC_LAT > 1))
                    | ((state == WAIT) && (wait_cnt != WAIT_LAST));
        ready_n     = ~hold_full_n & ~wait_next;
        load_data   = bypass ? in_if.data_i : hold_data;
        load_eop    = bypass ? in_if.eop_i  : hold_eop;
    end

    // Frame FSM, hold buffer, shifter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            hold_data      <= '0;
            hold_eop       <= 1'b0;
            hold_full      <= 1'b0;
            shift_reg      <= '0;
            shift_eop      <= 1'b0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            frame_open     <= 1'b0;
            in_if.ready_o  <= 1'b0;
            bit_o          <= 1'b0;
            bit_valid_o    <= 1'b0;
            crc_rst_o      <= 1'b1;
            crc_valid_o    <= 1'b0;
            err_underrun_o <= 1'b0;
            err_sop_o      <= 1'b0;
        end else begin
            crc_rst_o      <= 1'b0;
            crc_valid_o    <= 1'b0;
            err_underrun_o <= 1'b0;
            err_sop_o      <= accept & frame_open & in_if.sop_i;
            in_if.ready_o  <= ready_n;

            if (unload) begin
                hold_full <= 1'b0;
            end
            if (store) begin
                hold_full <= 1'b1;
                hold_data <= in_if.data_i;
                hold_eop  <= in_if.eop_i;
            end

            if (accept) begin
                if (frame_open) begin
                    if (in_if.eop_i) begin
                        frame_open <= 1'b0;
                    end
                end else if (in_if.sop_i) begin
                    frame_open <= ~in_if.eop_i;
                end
            end

            case (state)
                IDLE: begin
                    bit_o       <= 1'b0;
                    bit_valid_o <= 1'b0;
                    if (start_word || hold_full) begin
                        crc_rst_o <= 1'b1;
                        state     <= CLR;
                    end
                end

                CLR: begin
                    bit_o       <= first_bit(load_data);
                    shift_reg   <= drop_bit(load_data);
                    shift_eop   <= load_eop;
                    bit_cnt     <= '0;
                    bit_valid_o <= 1'b1;
                    state       <= SHIFT;
                end

                SHIFT: begin
                    if (last_bit) begin
                        if (shift_eop) begin
                            bit_o       <= 1'b0;
                            bit_valid_o <= 1'b0;
                            bit_cnt     <= '0;
                            if (CRC_LAT > 1) begin
                                wait_cnt <= WAIT_W'(1);
                                state    <= WAIT;
                            end else begin
                                crc_valid_o <= 1'b1;
                                state       <= IDLE;
                            end
                        end else if (hold_full || bypass) begin
                            bit_o       <= first_bit(load_data);
                            shift_reg   <= drop_bit(load_data);
                            shift_eop   <= load_eop;
                            bit_cnt     <= '0;
                            bit_valid_o <= 1'b1;
                        end else begin
                            bit_o          <= 1'b0;
                            bit_valid_o    <= 1'b0;
                            bit_cnt        <= '0;
                            err_underrun_o <= 1'b1;
                            crc_rst_o      <= 1'b1;
                            frame_open     <= 1'b0;
                            state          <= IDLE;
                        end
                    end else begin
                        bit_o       <= first_bit(shift_reg);
                        shift_reg   <= drop_bit(shift_reg);
                        bit_cnt     <= bit_cnt + CNT_W'(1);
                        bit_valid_o <= 1'b1;
                    end
                end

                WAIT: begin
                    bit_o       <= 1'b0;
                    bit_valid_o <= 1'b0;
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt    <= '0;
                        crc_valid_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_bit_serializer.sv
// Directed bench for crc_bit_serializer: drives framed bytes and follows the
// serial output with a bit-serial CRC-16/ARC model, checking bit order,
// frame timing, error pulses and the CRC value at each completion pulse.
module tb_crc_bit_serializer;

    localparam int DATA_W  = 8;
    localparam int CRC_LAT = 3;

    logic clk_i = 1'b0;
    logic rst_i;
    logic bit_o;
    logic bit_valid_o;
    logic crc_rst_o;
    logic crc_valid_o;
    logic err_underrun_o;
    logic err_sop_o;

    crc_bit_serializer_if #(.DATA_W(DATA_W)) in_if ();

    crc_bit_serializer #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (1'b1),
        .CRC_LAT   (CRC_LAT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_if          (in_if.slave),
        .bit_o          (bit_o),
        .bit_valid_o    (bit_valid_o),
        .crc_rst_o      (crc_rst_o),
        .crc_valid_o    (crc_valid_o),
        .err_underrun_o (err_underrun_o),
        .err_sop_o      (err_sop_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc              = 0;
    int          bits_total       = 0;
    int          rst_pulses       = 0;
    int          crc_valids       = 0;
    int          underruns        = 0;
    int          sop_errs         = 0;
    int          idle_bit_nonzero = 0;
    int          ready_rises      = 0;
    int          accepts          = 0;
    int          last_accept_cyc  = 0;
    int          last_rst_cyc     = 0;
    int          run_start_cyc    = 0;
    int          last_bit_cyc     = 0;
    int          cur_run          = 0;
    int          last_run_len     = 0;
    int          crc_valid_cyc    = 0;
    int          underrun_cyc     = 0;
    logic [15:0] crc_model        = 16'h0000;
    logic [15:0] crc_at_valid     = 16'h0000;
    logic [7:0]  run_bits         = 8'h00;
    logic        prev_bv          = 1'b0;
    logic        prev_crc_rst     = 1'b0;
    logic        prev_ready       = 1'b0;

    // One reflected CRC-16/ARC step (poly 0x8005 reflected = 0xA001).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    endfunction

    // Reference CRC of three bytes fed LSB first from a cleared register.
    function automatic logic [15:0] crc_of3(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
        logic [15:0] r;
        logic [23:0] s;
        r = 16'h0000;
        s = {c, b, a};
        for (int i = 0; i < 24; i++) r = crc_step(r, s[i]);
        return r;
    endfunction

    // Observes the DUT mid-cycle: CRC model, bit runs, pulses and handshakes.
    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (crc_rst_o) begin
            crc_model    <= 16'h0000;
            last_rst_cyc <= cyc;
        end else if (bit_valid_o) begin
            crc_model <= crc_step(crc_model, bit_o);
        end
        if (crc_rst_o && !prev_crc_rst) rst_pulses <= rst_pulses + 1;
        if (bit_valid_o) begin
            if (!prev_bv) begin
                run_start_cyc <= cyc;
                cur_run       <= 1;
                run_bits      <= {7'b0, bit_o};
            end else begin
                cur_run <= cur_run + 1;
                if (cur_run < 8) run_bits[cur_run[2:0]] <= bit_o;
            end
            last_bit_cyc <= cyc;
            bits_total   <= bits_total + 1;
        end else if (prev_bv) begin
            last_run_len <= cur_run;
        end
        if (!bit_valid_o && bit_o) idle_bit_nonzero <= idle_bit_nonzero + 1;
        if (crc_valid_o) begin
            crc_valids    <= crc_valids + 1;
            crc_at_valid  <= crc_model;
            crc_valid_cyc <= cyc;
        end
        if (err_underrun_o) begin
            underruns    <= underruns + 1;
            underrun_cyc <= cyc;
        end
        if (err_sop_o) sop_errs <= sop_errs + 1;
        if (in_if.ready_o && !prev_ready) ready_rises <= ready_rises + 1;
        if (in_if.valid_i && in_if.ready_o) begin
            accepts         <= accepts + 1;
            last_accept_cyc <= cyc;
        end
        prev_bv      <= bit_valid_o;
        prev_crc_rst <= crc_rst_o;
        prev_ready   <= in_if.ready_o;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic s, input logic e);
        int n;
        in_if.data_i  = d;
        in_if.sop_i   = s;
        in_if.eop_i   = e;
        in_if.valid_i = 1'b1;
        n = 0;
        while (!in_if.ready_o && n < 100) begin
            tick(1);
            n++;
        end
        if (!in_if.ready_o) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL send_timeout: ready_o %0b required 1", in_if.ready_o);
        end
        tick(1);
        in_if.valid_i = 1'b0;
        in_if.sop_i   = 1'b0;
        in_if.eop_i   = 1'b0;
    endtask

    task automatic wait_valids(input int target, output bit got);
        int n;
        n = 0;
        while (crc_valids < target && n < 120) begin
            tick(1);
            n++;
        end
        got = (crc_valids >= target);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(3);
        vectors++;
        if ({crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o} !== 7'b1000000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b required 1000000",
                     {crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o});
        end
        rst_i = 1'b0;
        tick(1);
        vectors++;
        if ({crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o} !== 7'b0100000) begin
            miscompares++;
            $display("[TB] FAIL release_outputs: got %b required 0100000",
                     {crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o});
        end
    endtask

    task automatic test_single_word();
        int v0;
        bit got;
        v0 = crc_valids;
        send_word(8'h01, 1'b1, 1'b1);
        wait_valids(v0 + 1, got);
        tick(2);
        vectors++;
        if (!got) begin miscompares++; $display("[TB] FAIL t1_valid_seen: got 0 required 1"); end
        vectors++;
        if (last_rst_cyc !== last_accept_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL t1_clear_cycle: got %0d required %0d", last_rst_cyc, last_accept_cyc + 1);
        end
        vectors++;
        if (run_start_cyc !== last_accept_cyc + 2) begin
            miscompares++;
            $display("[TB] FAIL t1_first_bit_cycle: got %0d required %0d", run_start_cyc, last_accept_cyc + 2);
        end
        vectors++;
        if (last_run_len !== 8) begin miscompares++; $display("[TB] FAIL t1_run_len: got %0d required 8", last_run_len); end
        vectors++;
        if (run_bits !== 8'h01) begin miscompares++; $display("[TB] FAIL t1_bit_order: got %h required 01", run_bits); end
        vectors++;
        if (crc_valid_cyc !== last_bit_cyc + CRC_LAT) begin
            miscompares++;
            $display("[TB] FAIL t1_valid_cycle: got %0d required %0d", crc_valid_cyc, last_bit_cyc + CRC_LAT);
        end
        vectors++;
        if (crc_at_valid !== 16'hC0C1) begin miscompares++; $display("[TB] FAIL t1_crc: got %h required c0c1", crc_at_valid); end
    endtask

    task automatic test_nine_bytes();
        int v0, b0, r0;
        bit got;
        logic [7:0] msg [9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        v0 = crc_valids;
        b0 = bits_total;
        r0 = ready_rises;
        for (int i = 0; i < 9; i++) send_word(msg[i], i == 0, i == 8);
        wait_valids(v0 + 1, got);
        tick(2);
        vectors++;
        if (last_run_len !== 72) begin miscompares++; $display("[TB] FAIL t2_gapless_run: got %0d required 72", last_run_len); end
        vectors++;
        if (bits_total - b0 !== 72) begin miscompares++; $display("[TB] FAIL t2_bit_count: got %0d required 72", bits_total - b0); end
        vectors++;
        if (crc_at_valid !== 16'hBB3D) begin miscompares++; $display("[TB] FAIL t2_crc: got %h required bb3d", crc_at_valid); end
        vectors++;
        if (ready_rises - r0 < 8) begin miscompares++; $display("[TB] FAIL t2_ready_toggle: got %0d required >=8", ready_rises - r0); end
        vectors++;
        if (crc_valid_cyc !== last_bit_cyc + CRC_LAT) begin
            miscompares++;
            $display("[TB] FAIL t2_valid_cycle: got %0d required %0d", crc_valid_cyc, last_bit_cyc + CRC_LAT);
        end
    endtask

    task automatic test_underrun();
        int v0, b0, u0, p0;
        bit got;
        v0 = crc_valids;
        b0 = bits_total;
        u0 = underruns;
        p0 = rst_pulses;
        send_word(8'hC3, 1'b1, 1'b0);
        tick(12);
        send_word(8'h3C, 1'b0, 1'b1);
        tick(10);
        vectors++;
        if (underruns - u0 !== 1) begin miscompares++; $display("[TB] FAIL t3_underrun_count: got %0d required 1", underruns - u0); end
        vectors++;
        if (underrun_cyc !== last_bit_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL t3_underrun_cycle: got %0d required %0d", underrun_cyc, last_bit_cyc + 1);
        end
        vectors++;
        if (last_rst_cyc !== last_bit_cyc + 1) begin
            miscompares++;
            $display("[TB] FAIL t3_clear_cycle: got %0d required %0d", last_rst_cyc, last_bit_cyc + 1);
        end
        vectors++;
        if (rst_pulses - p0 !== 2) begin miscompares++; $display("[TB] FAIL t3_clear_pulses: got %0d required 2", rst_pulses - p0); end
        vectors++;
        if (bits_total - b0 !== 8) begin miscompares++; $display("[TB] FAIL t3_bits: got %0d required 8", bits_total - b0); end
        vectors++;
        if (crc_valids - v0 !== 0) begin miscompares++; $display("[TB] FAIL t3_no_valid: got %0d required 0", crc_valids - v0); end
        send_word(8'h01, 1'b1, 1'b1);
        wait_valids(v0 + 1, got);
        tick(2);
        vectors++;
        if (!got || crc_at_valid !== 16'hC0C1) begin
            miscompares++;
            $display("[TB] FAIL t3_next_frame_crc: got %h required c0c1", crc_at_valid);
        end
    endtask

    task automatic test_sop_mid_frame();
        int v0, b0, s0, p0;
        bit got;
        logic [15:0] exp_crc;
        exp_crc = crc_of3(8'h11, 8'h22, 8'h33);
        v0 = crc_valids;
        b0 = bits_total;
        s0 = sop_errs;
        p0 = rst_pulses;
        send_word(8'h11, 1'b1, 1'b0);
        send_word(8'h22, 1'b1, 1'b0);
        send_word(8'h33, 1'b0, 1'b1);
        wait_valids(v0 + 1, got);
        tick(2);
        vectors++;
        if (sop_errs - s0 !== 1) begin miscompares++; $display("[TB] FAIL t4_sop_err: got %0d required 1", sop_errs - s0); end
        vectors++;
        if (bits_total - b0 !== 24 || last_run_len !== 24) begin
            miscompares++;
            $display("[TB] FAIL t4_bits: got %0d run %0d required 24", bits_total - b0, last_run_len);
        end
        vectors++;
        if (!got || crc_at_valid !== exp_crc) begin
            miscompares++;
            $display("[TB] FAIL t4_crc: got %h required %h", crc_at_valid, exp_crc);
        end
        vectors++;
        if (rst_pulses - p0 !== 1) begin miscompares++; $display("[TB] FAIL t4_clear_pulses: got %0d required 1", rst_pulses - p0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, u0;
        bit got;
        v0 = crc_valids;
        u0 = underruns;
        send_word(8'h5A, 1'b1, 1'b0);
        tick(5);
        vectors++;
        if (bit_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL t5_shifting: got %b required 1", bit_valid_o); end
        rst_i = 1'b1;
        tick(1);
        vectors++;
        if ({crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o} !== 7'b1000000) begin
            miscompares++;
            $display("[TB] FAIL t5_reset_outputs: got %b required 1000000",
                     {crc_rst_o, in_if.ready_o, bit_valid_o, bit_o, crc_valid_o, err_underrun_o, err_sop_o});
        end
        rst_i = 1'b0;
        tick(12);
        vectors++;
        if (crc_valids - v0 !== 0 || underruns - u0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL t5_aborted_quietly: got valids %0d underruns %0d required 0 0",
                     crc_valids - v0, underruns - u0);
        end
        send_word(8'h01, 1'b1, 1'b1);
        wait_valids(v0 + 1, got);
        tick(2);
        vectors++;
        if (!got || crc_at_valid !== 16'hC0C1) begin
            miscompares++;
            $display("[TB] FAIL t5_after_reset_crc: got %h required c0c1", crc_at_valid);
        end
    endtask

    task automatic test_idle_drop();
        int a0, b0, e0, p0;
        a0 = accepts;
        b0 = bits_total;
        e0 = underruns + sop_errs;
        p0 = rst_pulses;
        send_word(8'hAA, 1'b0, 1'b0);
        send_word(8'h55, 1'b0, 1'b1);
        tick(12);
        vectors++;
        if (accepts - a0 !== 2) begin miscompares++; $display("[TB] FAIL t6_accepts: got %0d required 2", accepts - a0); end
        vectors++;
        if (bits_total - b0 !== 0 || rst_pulses - p0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL t6_no_activity: got bits %0d clears %0d required 0 0", bits_total - b0, rst_pulses - p0);
        end
        vectors++;
        if (underruns + sop_errs - e0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL t6_no_errors: got %0d required 0", underruns + sop_errs - e0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, b0, s0, u0;
        bit got;
        v0 = crc_valids;
        b0 = bits_total;
        s0 = sop_errs;
        u0 = underruns;
        send_word(8'h01, 1'b1, 1'b1);
        send_word(8'h01, 1'b1, 1'b1);
        wait_valids(v0 + 2, got);
        tick(2);
        vectors++;
        if (!got || crc_valids - v0 !== 2) begin miscompares++; $display("[TB] FAIL t7_two_valids: got %0d required 2", crc_valids - v0); end
        vectors++;
        if (sop_errs - s0 !== 0 || underruns - u0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL t7_no_errors: got sop %0d underrun %0d required 0 0", sop_errs - s0, underruns - u0);
        end
        vectors++;
        if (bits_total - b0 !== 16) begin miscompares++; $display("[TB] FAIL t7_bits: got %0d required 16", bits_total - b0); end
        vectors++;
        if (crc_at_valid !== 16'hC0C1) begin miscompares++; $display("[TB] FAIL t7_crc: got %h required c0c1", crc_at_valid); end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        rst_i         = 1'b1;
        in_if.data_i  = '0;
        in_if.valid_i = 1'b0;
        in_if.sop_i   = 1'b0;
        in_if.eop_i   = 1'b0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_single_word();
        test_nine_bytes();
        test_underrun();
        test_sop_mid_frame();
        test_reset_mid_frame();
        test_idle_drop();
        test_back_to_back();
        vectors++;
        if (idle_bit_nonzero !== 0) begin
            miscompares++;
            $display("[TB] FAIL bit_zero_when_idle: got %0d cycles required 0", idle_bit_nonzero);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
